rx_fsrc_out_buffer: RTL

RX_FSRC_OUT_BUFFER -- requirements
Module: rx_fsrc_out_buffer

---
 rtl/rx_fsrc_out_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/rx_fsrc_out_buffer.sv
// Output FWFT buffer for the RX fractional sample-rate converter: captures a stream with no backpressure, drops on full.
// Optional feature: define RX_FSRC_OVF_COUNT_EN to add the 32-bit saturating ovf_count output.
module rx_fsrc_out_buffer #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    overflow_clr,
`ifdef RX_FSRC_OVF_COUNT_EN
  output logic [31:0]             ovf_count,
`endif
  output logic                    busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              capture, rd_en, wr_en, drop;
  logic [LW-1:0]     level_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state plus write/read/drop qualification
  always_comb begin
    state_next = state;
    capture    = ((state == S_ARMED) || (state == S_RUN)) && enable;
    rd_en      = out_valid && out_ready;
    wr_en      = capture && in_valid && ((level != LW'(DEPTH)) || rd_en);
    drop       = capture && in_valid && !wr_en;
    level_next = level;
    if (wr_en && !rd_en)      level_next = level + LW'(1);
    else if (rd_en && !wr_en) level_next = level - LW'(1);

    case (state)
      S_IDLE:  if (enable) state_next = S_ARMED;
      S_ARMED: begin
        if (!enable)       state_next = S_DRAIN;
        else if (in_valid) state_next = S_RUN;
      end
      S_RUN:   if (!enable) state_next = S_DRAIN;
      S_DRAIN: if (level == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level     <= level_next;
      out_valid <= (level_next != '0);
      busy      <= (state_next != S_IDLE);
      // A drop in the same cycle as a clear wins
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

`ifdef RX_FSRC_OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                  ovf_count <= '0;
    else if (overflow_clr)                      ovf_count <= {31'd0, drop};
    else if (drop && (ovf_count != 32'hFFFF_FFFF)) ovf_count <= ovf_count + 32'd1;
  end
`endif

  // Storage is not reset; head word falls through to the output
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  assign out_data = mem[rd_ptr];

endmodule
